nvram_arbiter: RTL and testbench

- Shares the game's single-port high-score NVRAM (256 x 4, X2212-equivalent) between two requesters.
- Requester 1 is the game CPU inside the core. Requester 2 is the HPS ioctl path: download restores a save, upload writes a save file out.
- Sequences the RAM control signals, arbitrates between the two, and tracks a dirty flag so the framework can trigger autosave.
- Sits between hps_io/CCastles and the NVRAM instance, in the clk domain.

---
 rtl/nvram_pkg.sv | 19 +
 rtl/nvram_hps_latch.sv | 54 +++++
 rtl/nvram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_nvram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvram_pkg.sv
// Shared types and defaults for the high-score NVRAM arbiter.
// Imported by the pending-request latch and the arbiter top.
package nvram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_HPS = 1'b1
    } owner_t;

    localparam int STREAK_MAX_DEF = 2;

endpackage

// File: rtl/nvram_hps_latch.sv
// Captures single-cycle HPS read/write pulses into a one-deep pending register.
// A pulse that arrives while a request is outstanding is dropped and flagged.
module nvram_hps_latch
    import nvram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_done,
    output logic              o_pend,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_din,
    output logic              o_ovf
);

    logic              r_pend;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_ovf;

    always_ff @(posedge clk) begin
        // NOTE: payload registers are reset along with the valid bit so nothing downstream ever sees X.
        if (!reset_n) begin
            r_pend <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
            r_ovf  <= 1'b0;
        end else if (r_pend) begin
            if (i_wr || i_rd) r_ovf <= 1'b1;
            if (i_done)       r_pend <= 1'b0;
        end else if (i_wr || i_rd) begin
            r_pend <= 1'b1;
            r_we   <= i_wr;
            r_addr <= i_addr;
            r_din  <= i_din;
        end
    end

    assign o_pend = r_pend;
    assign o_we   = r_we;
    assign o_addr = r_addr;
    assign o_din  = r_din;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/nvram_arbiter.sv
// Arbitrates the single-port high-score NVRAM between the game CPU and the HPS
// ioctl path, sequences the RAM strobes and tracks a CPU-write dirty flag.
module nvram_arbiter
    import nvram_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 4,
    parameter int STREAK_MAX = STREAK_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ack,
    input  logic              hps_wr,
    input  logic              hps_rd,
    input  logic [ADDR_W-1:0] hps_addr,
    input  logic [DATA_W-1:0] hps_din,
    output logic [DATA_W-1:0] hps_dout,
    output logic              hps_wait,
    input  logic              hps_upload_done,
    output logic              hps_ovf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dirty
);

    localparam int              SW         = $clog2(STREAK_MAX + 2);
    localparam logic [SW-1:0]   STREAK_TOP = SW'(STREAK_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    owner_t            r_owner;
    logic [SW-1:0]     r_streak;
    logic              r_cpu_ack;
    logic [DATA_W-1:0] r_cpu_dout;
    logic [DATA_W-1:0] r_hps_dout;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_dirty;

    logic              w_hps_pend;
    logic              w_hps_we;
    logic [ADDR_W-1:0] w_hps_addr;
    logic [DATA_W-1:0] w_hps_din;
    logic              w_cpu_elig;
    logic              w_grant_cpu;
    logic              w_grant_hps;
    logic              w_grant_we;
    logic              w_done;
    logic              w_cpu_done;
    logic              w_hps_done;

    nvram_hps_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hps_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .i_wr    (hps_wr),
        .i_rd    (hps_rd),
        .i_addr  (hps_addr),
        .i_din   (hps_din),
        .i_done  (w_hps_done),
        .o_pend  (w_hps_pend),
        .o_we    (w_hps_we),
        .o_addr  (w_hps_addr),
        .o_din   (w_hps_din),
        .o_ovf   (hps_ovf)
    );

    // A request acked this cycle must not be granted again on the same level.
    assign w_cpu_elig = cpu_req && !r_cpu_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_cpu = 1'b0;
        w_grant_hps = 1'b0;
        w_grant_we  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hps_pend && (!w_cpu_elig || r_streak != STREAK_TOP)) w_grant_hps = 1'b1;
                else if (w_cpu_elig)                                        w_grant_cpu = 1'b1;
                w_grant_we = w_grant_hps ? w_hps_we : cpu_we;
                if (w_grant_hps || w_grant_cpu) w_state_nxt = w_grant_we ? WR : RD;
            end
            WR: begin
                w_state_nxt = IDLE;
                w_done      = 1'b1;
            end
            RD:      w_state_nxt = RD_DATA;
            RD_DATA: begin
                w_state_nxt = IDLE;
                w_done      = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_cpu_done = w_done && (r_owner == OWN_CPU);
    assign w_hps_done = w_done && (r_owner == OWN_HPS);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_owner     <= OWN_CPU;
            r_streak    <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_dout  <= '0;
            r_hps_dout  <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_dirty     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_we  <= 1'b0;
            r_cpu_ack <= w_cpu_done;
            if (w_grant_hps) begin
                r_owner    <= OWN_HPS;
                r_mem_addr <= w_hps_addr;
                r_mem_we   <= w_hps_we;
                if (w_hps_we) r_mem_wdata <= w_hps_din;
            end else if (w_grant_cpu) begin
                r_owner    <= OWN_CPU;
                r_mem_addr <= cpu_addr;
                r_mem_we   <= cpu_we;
                if (cpu_we) r_mem_wdata <= cpu_din;
            end
            if (w_grant_cpu)
                r_streak <= '0;
            else if (w_grant_hps && w_cpu_elig && r_streak != STREAK_TOP)
                r_streak <= r_streak + 1'b1;
            if (r_state == RD_DATA) begin
                if (r_owner == OWN_CPU) r_cpu_dout <= mem_rdata;
                else                    r_hps_dout <= mem_rdata;
            end
            // A CPU write completing on the same edge as upload_done keeps the flag set.
            if (w_cpu_done && r_state == WR) r_dirty <= 1'b1;
            else if (hps_upload_done)        r_dirty <= 1'b0;
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign cpu_dout  = r_cpu_dout;
    assign hps_dout  = r_hps_dout;
    assign hps_wait  = w_hps_pend;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign dirty     = r_dirty;

endmodule

// File: tb/tb_nvram_arbiter.sv
// Self-checking bench for nvram_arbiter: directed scenarios plus a randomized
// mix of CPU/HPS accesses checked against a transaction-level memory model.
module tb_nvram_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 4;
    localparam int SMAX = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din, cpu_dout;
    logic          cpu_ack;
    logic          hps_wr, hps_rd;
    logic [AW-1:0] hps_addr;
    logic [DW-1:0] hps_din, hps_dout;
    logic          hps_wait, hps_upload_done, hps_ovf;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          dirty;

    always #5 clk = ~clk;

    nvram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(SMAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .hps_wr(hps_wr), .hps_rd(hps_rd), .hps_addr(hps_addr), .hps_din(hps_din),
        .hps_dout(hps_dout), .hps_wait(hps_wait), .hps_upload_done(hps_upload_done),
        .hps_ovf(hps_ovf),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dirty(dirty)
    );

    // Environment RAM: synchronous write, one-cycle registered read.
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_q <= ram[mem_addr];
    end
    assign mem_rdata = ram_q;

    // Reference model: what the memory should hold and whether it is dirty.
    logic [DW-1:0] ref_mem [0:255];
    logic          ref_dirty;

    int n_cmp = 0;
    int n_err = 0;

    // Grant observer used by the back-to-back scenario.
    bit            mon_on = 1'b0;
    logic [AW-1:0] grant_q [$];
    always @(negedge clk) if (mon_on && mem_we) grant_q.push_back(mem_addr);

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // CPU access: raise request at a negedge, hold it through the ack cycle.
    task automatic cpu_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input bit done_in_wr, output int lat, output logic [DW-1:0] rd,
                              output int we_cycles, output logic [AW-1:0] we_a,
                              output logic [DW-1:0] we_d);
        lat = -1; rd = '0; we_cycles = 0; we_a = '0; we_d = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            hps_upload_done = 1'b0;
            if (mem_we) begin
                we_cycles++; we_a = mem_addr; we_d = mem_wdata;
                if (done_in_wr) hps_upload_done = 1'b1;
            end
            if (cpu_ack) begin lat = i; rd = cpu_dout; break; end
        end
        @(posedge clk);
        #1 cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        if (mem_we) we_cycles++;
        if (we && lat > 0) begin ref_mem[a] = d; ref_dirty = 1'b1; end
    endtask

    // HPS access: single-cycle pulse, then wait (bounded) for hps_wait to fall.
    task automatic hps_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input bit extra_pulse, output int lat, output logic [DW-1:0] rd);
        lat = -1; rd = '0;
        hps_wr = wr; hps_rd = !wr; hps_addr = a; hps_din = d;
        @(negedge clk);
        hps_wr = 1'b0; hps_rd = 1'b0;
        n_cmp++;
        if (hps_wait !== 1'b1) begin n_err++; $display("FAIL hps_wait_rise: got %b want 1", hps_wait); end
        if (extra_pulse) begin hps_rd = 1'b1; hps_addr = a ^ 8'h30; end
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            hps_rd = 1'b0;
            if (!hps_wait) begin lat = i; rd = hps_dout; break; end
        end
        if (wr && lat > 0) ref_mem[a] = d;
    endtask

    task automatic pulse_upload_done();
        hps_upload_done = 1'b1;
        @(negedge clk);
        hps_upload_done = 1'b0;
        ref_dirty = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_req = 1'(i); cpu_we = 1'b1; cpu_addr = 8'hFF; cpu_din = 4'hF;
            hps_wr = 1'(i); hps_addr = 8'h55; hps_din = 4'h9;
        end
        @(negedge clk);
        n_cmp++;
        if ({cpu_ack, cpu_dout, hps_dout, hps_wait, hps_ovf, mem_we, mem_addr, mem_wdata, dirty} !== '0) begin
            n_err++;
            $display("FAIL reset_in_reset: ack=%b cdout=%h hdout=%h wait=%b ovf=%b we=%b addr=%h wd=%h dirty=%b want all 0",
                     cpu_ack, cpu_dout, hps_dout, hps_wait, hps_ovf, mem_we, mem_addr, mem_wdata, dirty);
        end
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0; hps_wr = 0; hps_addr = 0; hps_din = 0;
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cpu_ack, hps_wait, hps_ovf, mem_we, dirty} !== '0) begin
            n_err++;
            $display("FAIL reset_release: ack=%b wait=%b ovf=%b we=%b dirty=%b want all 0",
                     cpu_ack, hps_wait, hps_ovf, mem_we, dirty);
        end
    endtask

    task automatic test_cpu_write();
        int lat, wc; logic [DW-1:0] rd; logic [AW-1:0] wa; logic [DW-1:0] wd;
        cpu_access(1'b1, 8'h10, 4'hA, 1'b0, lat, rd, wc, wa, wd);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL cpu_wr_latency: got %0d want 2", lat); end
        n_cmp++; if (wc !== 1) begin n_err++; $display("FAIL cpu_wr_we_cycles: got %0d want 1", wc); end
        n_cmp++; if ({wa, wd} !== {8'h10, 4'hA}) begin n_err++; $display("FAIL cpu_wr_bus: got %h/%h want 10/a", wa, wd); end
        n_cmp++; if (dirty !== 1'b1) begin n_err++; $display("FAIL cpu_wr_dirty: got %b want 1", dirty); end
    endtask

    task automatic test_cpu_read();
        int lat, wc, spurious; logic [DW-1:0] rd; logic [AW-1:0] wa; logic [DW-1:0] wd;
        cpu_access(1'b0, 8'h10, 4'h0, 1'b0, lat, rd, wc, wa, wd);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL cpu_rd_latency: got %0d want 3", lat); end
        n_cmp++; if (rd !== ref_mem[8'h10]) begin n_err++; $display("FAIL cpu_rd_data: got %h want %h", rd, ref_mem[8'h10]); end
        spurious = 0;
        for (int i = 0; i < 4; i++) begin
            if (cpu_ack || mem_we) spurious++;
            @(negedge clk);
        end
        n_cmp++; if (spurious !== 0) begin n_err++; $display("FAIL cpu_rd_no_reack: got %0d extra cycles want 0", spurious); end
        n_cmp++; if (cpu_dout !== ref_mem[8'h10]) begin n_err++; $display("FAIL cpu_dout_hold: got %h want %h", cpu_dout, ref_mem[8'h10]); end
    endtask

    task automatic test_back_to_back();
        int lat, run, max_run, n_cpu, n_hps; logic [DW-1:0] rd;
        pulse_upload_done();
        hps_access(1'b1, 8'h21, 4'h6, 1'b0, lat, rd);
        hps_access(1'b1, 8'h22, 4'h7, 1'b0, lat, rd);
        n_cmp++; if (dirty !== 1'b0) begin n_err++; $display("FAIL hps_wr_no_dirty: got %b want 0", dirty); end
        grant_q.delete();
        mon_on = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_din = 4'h3;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (hps_wr) hps_wr = 1'b0;
            else if (!hps_wait) begin hps_wr = 1'b1; hps_addr = 8'h20; hps_din = 4'h5; end
        end
        hps_wr = 1'b0;
        @(posedge clk);
        #1 cpu_req = 1'b0; cpu_we = 1'b0;
        for (int c = 0; c < 8; c++) @(negedge clk);
        mon_on = 1'b0;
        run = 0; max_run = 0; n_cpu = 0; n_hps = 0;
        foreach (grant_q[i]) begin
            if (grant_q[i] == 8'h20) begin n_hps++; run++; if (run > max_run) max_run = run; end
            else begin n_cpu++; run = 0; end
        end
        ref_mem[8'h20] = 4'h5; ref_mem[8'h30] = 4'h3; ref_dirty = 1'b1;
        n_cmp++; if (max_run > SMAX) begin n_err++; $display("FAIL b2b_streak: got run %0d want <= %0d", max_run, SMAX); end
        n_cmp++; if (n_cpu < 3) begin n_err++; $display("FAIL b2b_cpu_progress: got %0d grants want >= 3", n_cpu); end
        n_cmp++; if (n_hps < 3) begin n_err++; $display("FAIL b2b_hps_progress: got %0d grants want >= 3", n_hps); end
        n_cmp++; if (hps_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_no_ovf: got %b want 0", hps_ovf); end
        n_cmp++; if (dirty !== ref_dirty) begin n_err++; $display("FAIL b2b_dirty: got %b want %b", dirty, ref_dirty); end
    endtask

    task automatic test_hps_read_ovf();
        int lat, busy; logic [DW-1:0] rd;
        hps_access(1'b0, 8'h20, 4'h0, 1'b1, lat, rd);
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL hps_rd_latency: got %0d want 4", lat); end
        n_cmp++; if (rd !== 4'h5) begin n_err++; $display("FAIL hps_rd_data: got %h want 5", rd); end
        busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (hps_wait || mem_we) busy++;
        end
        n_cmp++; if (busy !== 0) begin n_err++; $display("FAIL hps_second_ignored: got %0d busy cycles want 0", busy); end
        n_cmp++; if (hps_ovf !== 1'b1) begin n_err++; $display("FAIL hps_ovf_sticky: got %b want 1", hps_ovf); end
        n_cmp++; if (hps_dout !== 4'h5) begin n_err++; $display("FAIL hps_dout_hold: got %h want 5", hps_dout); end
    endtask

    task automatic test_dirty_race();
        int lat, wc; logic [DW-1:0] rd; logic [AW-1:0] wa; logic [DW-1:0] wd;
        pulse_upload_done();
        // upload_done is sampled on the same edge that completes the CPU write.
        cpu_access(1'b1, 8'h11, 4'h7, 1'b1, lat, rd, wc, wa, wd);
        n_cmp++; if (dirty !== 1'b1) begin n_err++; $display("FAIL dirty_set_wins: got %b want 1", dirty); end
        pulse_upload_done();
        n_cmp++; if (dirty !== 1'b0) begin n_err++; $display("FAIL dirty_clear: got %b want 0", dirty); end
    endtask

    task automatic test_random();
        int lat, wc, op; logic [DW-1:0] rd, d; logic [AW-1:0] a, wa; logic [DW-1:0] wd;
        for (int i = 0; i < 8; i++) begin
            hps_access(1'b1, 8'h40 + AW'(i), DW'($urandom), 1'b0, lat, rd);
            n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rnd_init_latency: got %0d want 3", lat); end
        end
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 4);
            a  = AW'($urandom_range(8'h40, 8'h47));
            d  = DW'($urandom);
            case (op)
                0: begin
                    cpu_access(1'b1, a, d, 1'b0, lat, rd, wc, wa, wd);
                    n_cmp++; if (lat !== 2 || wa !== a || wd !== d) begin n_err++;
                        $display("FAIL rnd_cpu_wr: lat %0d bus %h/%h want 2 %h/%h", lat, wa, wd, a, d); end
                end
                1: begin
                    cpu_access(1'b0, a, d, 1'b0, lat, rd, wc, wa, wd);
                    n_cmp++; if (lat !== 3 || rd !== ref_mem[a]) begin n_err++;
                        $display("FAIL rnd_cpu_rd: lat %0d data %h want 3 %h", lat, rd, ref_mem[a]); end
                end
                2: begin
                    hps_access(1'b1, a, d, 1'b0, lat, rd);
                    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rnd_hps_wr: lat %0d want 3", lat); end
                end
                3: begin
                    hps_access(1'b0, a, d, 1'b0, lat, rd);
                    n_cmp++; if (lat !== 4 || rd !== ref_mem[a]) begin n_err++;
                        $display("FAIL rnd_hps_rd: lat %0d data %h want 4 %h", lat, rd, ref_mem[a]); end
                end
                default: pulse_upload_done();
            endcase
            n_cmp++; if (dirty !== ref_dirty) begin n_err++; $display("FAIL rnd_dirty op%0d: got %b want %b", op, dirty, ref_dirty); end
        end
    endtask

    task automatic test_reset_mid();
        int lat, wc; logic [DW-1:0] rd; logic [AW-1:0] wa; logic [DW-1:0] wd;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cpu_ack, cpu_dout, hps_dout, hps_wait, hps_ovf, mem_we, mem_addr, mem_wdata, dirty} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: ack=%b cdout=%h hdout=%h wait=%b ovf=%b we=%b addr=%h wd=%h dirty=%b want all 0",
                     cpu_ack, cpu_dout, hps_dout, hps_wait, hps_ovf, mem_we, mem_addr, mem_wdata, dirty);
        end
        reset_n = 1'b1;
        ref_dirty = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL reset_mid_no_ack: got %b want 0", cpu_ack); end
        cpu_access(1'b0, 8'h10, 4'h0, 1'b0, lat, rd, wc, wa, wd);
        n_cmp++; if (lat !== 3 || rd !== ref_mem[8'h10]) begin n_err++;
            $display("FAIL reset_mid_idle: lat %0d data %h want 3 %h", lat, rd, ref_mem[8'h10]); end
    endtask

    initial begin
        reset_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
        hps_wr = 0; hps_rd = 0; hps_addr = 0; hps_din = 0; hps_upload_done = 0;
        ref_dirty = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_back_to_back();
        test_hps_read_ovf();
        test_dirty_race();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
